bram_wb_arbiter: RTL and testbench
==================================

BRAM_WB_ARBITER -- requirements
Module: bram_wb_arbiter

Interface
REQ-001: Parameter AW, default 13, BRAM word-address width.
REQ-002: Parameter DW, default 13, BRAM write-data width.
REQ-003: Parameter DEPTH, default 5120, number of valid BRAM words; legal addresses are 0..DEPTH-1.
REQ-004: CLK  in  1  single clock; all logic on rising edge.
REQ-005: RSTN  in  1  reset, synchronous and active-high (despite the name).
REQ-006: START_SIGNAL  in  1  GPIO run request; acted on at its rising edge only.
REQ-007: STOP_SIGNAL  in  1  run-end request from the SIMD core.
REQ-008: H_VALID / H_READY  in / out  1 / 1  host (AXI loader) write handshake.
REQ-009: H_ADDR / H_DATA  in  AW / DW  host write address and data.
REQ-010: C_VALID / C_READY  in / out  1 / 1  core write-back handshake.
REQ-011: C_ADDR / C_DATA  in  AW / DW  core write address and data.
REQ-012: WBEN / WBADDR / WBVALUE  out  1 / AW / DW  registered BRAM write port.
REQ-013: BUSY  out  1  high in RUN and DRAIN.
REQ-014: DONE  out  1  one-cycle pulse on DRAIN->IDLE.
REQ-015: ERR  out  1  sticky flag: an out-of-range address was accepted.

Function
REQ-016: States IDLE, RUN, DRAIN; READY outputs are combinational from state, VALIDs and the last-grant register.
REQ-017: A beat transfers when VALID && READY; WBEN rises the next cycle for exactly one cycle with that beat's address/data (latency 1).
REQ-018: WBADDR/WBVALUE hold their last value while WBEN is low.
REQ-019: IDLE: H_READY=1, C_READY=0; a START_SIGNAL rising edge (registered previous sample low, current high) moves to RUN next cycle.
REQ-020: IDLE: STOP_SIGNAL is ignored; START_SIGNAL held high after a run does not restart until it falls and rises again.
REQ-021: RUN: a sole valid requester is granted; when both are valid, the requester not granted last wins, and the grant register updates on every transfer.
REQ-022: Grant register resets to host, so the core wins the first contention.
REQ-023: RUN: STOP_SIGNAL high moves to DRAIN next cycle; a transfer in that same cycle still completes.
REQ-024: DRAIN: C_READY=1, H_READY=0; moves to IDLE on the cycle after the first cycle with C_VALID=0; DONE pulses in the first IDLE cycle.
REQ-025: A transfer with address >= DEPTH is accepted (READY honoured) but WBEN stays low; ERR sets next cycle.
REQ-026: ERR clears only on reset or on IDLE->RUN.
REQ-027: At most one BRAM write per cycle; back-to-back transfers yield WBEN high on consecutive cycles.

Reset
REQ-028: RSTN high: state=IDLE, WBEN=0, WBADDR=0, WBVALUE=0, BUSY=0, DONE=0, ERR=0, grant=host, start-edge register=0.
REQ-029: Reset mid-run overrides all transitions; a beat accepted in the cycle before reset is discarded (no WBEN after reset).

Configuration
REQ-030: Macro BRAM_ARB_COUNT_EN defined: add output WR_COUNT[15:0], counting WBEN=1 cycles, saturating at 0xFFFF, cleared on reset and on IDLE->RUN.
REQ-031: Macro BRAM_ARB_COUNT_EN undefined: no WR_COUNT port or counter logic; all other behaviour identical.

Verification
REQ-032: IDLE, H_VALID=1, H_ADDR=0x010, H_DATA=0x0AB, C_VALID=1 -> H_READY=1, C_READY=0; next cycle WBEN=1, WBADDR=0x010, WBVALUE=0x0AB; no core write.
REQ-033: START_SIGNAL 0->1, then both valid for 4 cycles (core addr 0x100.., host addr 0x200..) -> writes alternate core, host, core, host.
REQ-034: RUN, STOP_SIGNAL=1 while C_VALID stays high 3 more cycles then drops -> 3 core writes in DRAIN, host blocked, DONE pulses once, BUSY falls with it.
REQ-035: RUN, C_ADDR=5120 accepted -> no WBEN, ERR=1 next cycle; ERR holds through DRAIN/IDLE; clears on next START rising edge.
REQ-036: RUN with a beat accepted, RSTN=1 next cycle -> WBEN=0, state IDLE, all outputs at reset values; with BRAM_ARB_COUNT_EN, 10 writes then reset -> WR_COUNT 10 then 0.

Source files
------------

// File: rtl/bram_wb_arbiter.sv
// Two-master (host loader / SIMD core) write arbiter onto a single registered BRAM write port.
// Optional macro BRAM_ARB_COUNT_EN adds a saturating WR_COUNT output of issued BRAM writes.
module bram_wb_arbiter #(
    parameter int AW    = 13,
    parameter int DW    = 13,
    parameter int DEPTH = 5120
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START_SIGNAL,
    input  logic          STOP_SIGNAL,
    input  logic          H_VALID,
    output logic          H_READY,
    input  logic [AW-1:0] H_ADDR,
    input  logic [DW-1:0] H_DATA,
    input  logic          C_VALID,
    output logic          C_READY,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_DATA,
    output logic          WBEN,
    output logic [AW-1:0] WBADDR,
    output logic [DW-1:0] WBVALUE,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [1:0]    DBG_STATE
`ifdef BRAM_ARB_COUNT_EN
    ,
    output logic [15:0]   WR_COUNT
`endif
);

    // Handshake: a beat moves on a rising edge where VALID && READY; the source
    // holds address/data stable until then, and READY never waits on a transfer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    state_t        state;
    logic          start_q;
    logic          last_core;
    logic          h_fire;
    logic          c_fire;
    logic          fire;
    logic          start_rise;
    logic          in_range;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // last_core=0 means host was granted last, so the core wins the next tie.
    always_comb begin
        H_READY = 1'b0;
        C_READY = 1'b0;
        case (state)
            ST_IDLE:  H_READY = 1'b1;
            ST_RUN: begin
                H_READY = H_VALID && (!C_VALID || last_core);
                C_READY = C_VALID && (!H_VALID || !last_core);
            end
            ST_DRAIN: C_READY = 1'b1;
            default: begin
                H_READY = 1'b0;
                C_READY = 1'b0;
            end
        endcase
    end

    assign h_fire     = H_VALID && H_READY;
    assign c_fire     = C_VALID && C_READY;
    assign fire       = h_fire || c_fire;
    assign start_rise = START_SIGNAL && !start_q;
    assign sel_addr   = c_fire ? C_ADDR : H_ADDR;
    assign sel_data   = c_fire ? C_DATA : H_DATA;
    assign in_range   = {1'b0, sel_addr} < DEPTH_L;
    assign DBG_STATE  = state;

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            last_core <= 1'b0;
            WBEN      <= 1'b0;
            WBADDR    <= '0;
            WBVALUE   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            start_q <= START_SIGNAL;
            DONE    <= 1'b0;
            if (fire) begin
                last_core <= c_fire;
            end
            if (fire && in_range) begin
                WBEN    <= 1'b1;
                WBADDR  <= sel_addr;
                WBVALUE <= sel_data;
            end else begin
                WBEN <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state <= ST_RUN;
                        BUSY  <= 1'b1;
                        ERR   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (STOP_SIGNAL) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!C_VALID) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A bad address accepted on the same edge as a run start still flags.
            if (fire && !in_range) begin
                ERR <= 1'b1;
            end
        end
    end

`ifdef BRAM_ARB_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            WR_COUNT <= '0;
        end else if (state == ST_IDLE && start_rise) begin
            WR_COUNT <= '0;
        end else if (WBEN && WR_COUNT != 16'hFFFF) begin
            WR_COUNT <= WR_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_wb_arbiter.sv
// Directed bench for bram_wb_arbiter: expected BRAM writes are queued at issue time
// and a negedge monitor pops and compares them whenever WBEN is high.
module tb_bram_wb_arbiter;

    localparam int AW = 13;
    localparam int DW = 13;
    localparam int W  = AW + DW;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b1;
    logic          START_SIGNAL = 1'b0;
    logic          STOP_SIGNAL = 1'b0;
    logic          H_VALID = 1'b0;
    logic          H_READY;
    logic [AW-1:0] H_ADDR = '0;
    logic [DW-1:0] H_DATA = '0;
    logic          C_VALID = 1'b0;
    logic          C_READY;
    logic [AW-1:0] C_ADDR = '0;
    logic [DW-1:0] C_DATA = '0;
    logic          WBEN;
    logic [AW-1:0] WBADDR;
    logic [DW-1:0] WBVALUE;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [1:0]    DBG_STATE;
`ifdef BRAM_ARB_COUNT_EN
    logic [15:0]   WR_COUNT;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    bram_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(5120)) dut (
        .CLK(CLK), .RSTN(RSTN), .START_SIGNAL(START_SIGNAL), .STOP_SIGNAL(STOP_SIGNAL),
        .H_VALID(H_VALID), .H_READY(H_READY), .H_ADDR(H_ADDR), .H_DATA(H_DATA),
        .C_VALID(C_VALID), .C_READY(C_READY), .C_ADDR(C_ADDR), .C_DATA(C_DATA),
        .WBEN(WBEN), .WBADDR(WBADDR), .WBVALUE(WBVALUE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
`ifdef BRAM_ARB_COUNT_EN
        , .WR_COUNT(WR_COUNT)
`endif
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s act=0x%0h req=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        logic [W-1:0] e;
        if (WBEN === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write act=%0h/%0h req=none", WBADDR, WBVALUE);
            end else begin
                e = exp_q.pop_front();
                if ({WBADDR, WBVALUE} !== e) begin
                    fails++;
                    $display("FAIL bram_write act=%0h/%0h req=%0h/%0h",
                             WBADDR, WBVALUE, e[W-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        int ci;
        int hi;
        // reset
        RSTN = 1'b1;
        repeat (3) step();
        RSTN = 1'b0;
        #1;
        check("rst_wben", WBEN, 0);
        check("rst_wbaddr", WBADDR, 0);
        check("rst_wbvalue", WBVALUE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_state", DBG_STATE, 0);

        // idle: host owns the port, core is held off
        H_VALID = 1; H_ADDR = 13'h010; H_DATA = 13'h0AB;
        C_VALID = 1; C_ADDR = 13'h011; C_DATA = 13'h055;
        #1;
        check("idle_h_ready", H_READY, 1);
        check("idle_c_ready", C_READY, 0);
        push_exp(13'h010, 13'h0AB);
        step();
        H_VALID = 0; C_VALID = 0;
        step();

        // start rising edge, then alternating contention
        START_SIGNAL = 1;
        step();
        push_exp(13'h100, 13'h0C0);
        push_exp(13'h200, 13'h0A0);
        push_exp(13'h101, 13'h0C1);
        push_exp(13'h201, 13'h0A1);
        ci = 0; hi = 0;
        for (int k = 0; k < 4; k++) begin
            H_VALID = 1; H_ADDR = 13'(13'h200 + hi); H_DATA = 13'(13'h0A0 + hi);
            C_VALID = 1; C_ADDR = 13'(13'h100 + ci); C_DATA = 13'(13'h0C0 + ci);
            #1;
            check("run_busy", BUSY, 1);
            check("arb_c_ready", C_READY, ((k % 2) == 0) ? 1 : 0);
            check("arb_h_ready", H_READY, ((k % 2) == 1) ? 1 : 0);
            if ((k % 2) == 0) ci++; else hi++;
            step();
        end

        // stop with a beat in the same cycle, then drain three core beats
        H_VALID = 0;
        STOP_SIGNAL = 1; C_VALID = 1; C_ADDR = 13'h2FF; C_DATA = 13'h111;
        #1;
        check("stop_c_ready", C_READY, 1);
        push_exp(13'h2FF, 13'h111);
        step();
        for (int i = 0; i < 3; i++) begin
            C_VALID = 1; C_ADDR = 13'(13'h300 + i); C_DATA = 13'(13'h120 + i);
            H_VALID = 1; H_ADDR = 13'h3FF; H_DATA = 13'h1FF;
            #1;
            check("drain_c_ready", C_READY, 1);
            check("drain_h_ready", H_READY, 0);
            check("drain_busy", BUSY, 1);
            push_exp(13'(13'h300 + i), 13'(13'h120 + i));
            step();
        end
        C_VALID = 0; H_VALID = 0; STOP_SIGNAL = 0;
        #1;
        check("drain_done_low", DONE, 0);
        step();
        check("done_pulse", DONE, 1);
        check("busy_fall", BUSY, 0);
        step();
        check("done_single", DONE, 0);

        // start held high must not restart
        step();
        check("no_restart", BUSY, 0);

        // out-of-range beat, then DEPTH-1 is still legal
        START_SIGNAL = 0;
        step();
        START_SIGNAL = 1;
        step();
        check("run2_busy", BUSY, 1);
        check("run2_err", ERR, 0);
        C_VALID = 1; C_ADDR = 13'd5120; C_DATA = 13'h001;
        step();
        C_ADDR = 13'd5119; C_DATA = 13'h077;
        push_exp(13'd5119, 13'h077);
        #1;
        check("err_set", ERR, 1);
        check("oob_no_wben", WBEN, 0);
        check("hold_wbaddr", WBADDR, 13'h302);
        check("hold_wbvalue", WBVALUE, 13'h122);
        step();
        C_VALID = 0; STOP_SIGNAL = 1;
        step();
        STOP_SIGNAL = 0;
        step();
        check("err_hold_idle", ERR, 1);
        check("idle_state", DBG_STATE, 0);
        START_SIGNAL = 0;
        step();
        START_SIGNAL = 1;
        step();
        check("err_clear", ERR, 0);

        // reset right after an accepted beat
        H_VALID = 1; H_ADDR = 13'h050; H_DATA = 13'h0EE;
        push_exp(13'h050, 13'h0EE);
        step();
        H_VALID = 0; RSTN = 1; START_SIGNAL = 0;
        step();
        RSTN = 0;
        #1;
        check("rst2_wben", WBEN, 0);
        check("rst2_wbaddr", WBADDR, 0);
        check("rst2_wbvalue", WBVALUE, 0);
        check("rst2_busy", BUSY, 0);
        check("rst2_err", ERR, 0);
        check("rst2_state", DBG_STATE, 0);
        check("rst2_h_ready", H_READY, 1);
        check("rst2_c_ready", C_READY, 0);
        step();
        check("rst2_no_write", WBEN, 0);

`ifdef BRAM_ARB_COUNT_EN
        START_SIGNAL = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            H_VALID = 1; H_ADDR = 13'(i); H_DATA = 13'(13'h040 + i);
            push_exp(13'(i), 13'(13'h040 + i));
            step();
        end
        H_VALID = 0;
        step();
        check("wr_count_10", WR_COUNT, 10);
        RSTN = 1; START_SIGNAL = 0;
        step();
        RSTN = 0;
        #1;
        check("wr_count_rst", WR_COUNT, 0);
`endif

        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
